// File: rtl/dark_block_min_if.sv
// Cell-minimum input stream and block dark-channel output stream.
interface dark_block_min_if #(
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 6
) ();
  logic             frame_start;
  logic             valid_min_RGB;
  logic [23:0]      min_RGB;
  logic             valid_dark;
  logic [7:0]       dark_val;
  logic [COL_W-1:0] dark_col;
  logic [ROW_W-1:0] dark_row;
  logic             frame_done;

  // Producer of cell minima, consumer of dark values
  modport master (
    output frame_start, valid_min_RGB, min_RGB,
    input  valid_dark, dark_val, dark_col, dark_row, frame_done
  );

  // The dark-channel block itself
  modport slave (
    input  frame_start, valid_min_RGB, min_RGB,
    output valid_dark, dark_val, dark_col, dark_row, frame_done
  );
endinterface

// File: rtl/dark_block_min.sv
// Block dark-channel minimum: per-cell min(R,G,B), then vertical min over
// BLOCK_ROWS lines through a one-line cell buffer; one result per block.
module dark_block_min #(
  parameter int unsigned CELLS_PER_LINE = 80,
  parameter int unsigned BLOCK_ROWS     = 24,
  parameter int unsigned BLOCKS_PER_FRM = 45,
  parameter int unsigned COL_W          = 7,
  parameter int unsigned ROW_W          = 6
) (
  input  logic          clkn,
  input  logic          resetn,
  dark_block_min_if.slave io_bus
);

  localparam int unsigned LINE_W = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(CELLS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(BLOCK_ROWS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(BLOCKS_PER_FRM - 1);

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_line;
  logic [ROW_W-1:0]  r_row;
  logic [7:0]        r_mem [CELLS_PER_LINE];

  logic [7:0]        w_d;
  logic [COL_W-1:0]  w_col;
  logic [LINE_W-1:0] w_line;
  logic [ROW_W-1:0]  w_row;
  logic [7:0]        w_mem_rd;
  logic [7:0]        w_out_val;
  logic              w_beat;
  logic              w_last_col;
  logic              w_last_line;
  logic              w_last_row;

  // A frame_start coinciding with a beat makes that beat position (0,0)
  assign w_beat      = io_bus.valid_min_RGB;
  assign w_d         = min8(min8(io_bus.min_RGB[23:16], io_bus.min_RGB[15:8]),
                            io_bus.min_RGB[7:0]);
  assign w_col       = io_bus.frame_start ? '0 : r_col;
  assign w_line      = io_bus.frame_start ? '0 : r_line;
  assign w_row       = io_bus.frame_start ? '0 : r_row;
  assign w_mem_rd    = r_mem[w_col];
  assign w_last_col  = (w_col == LAST_COL);
  assign w_last_line = (w_line == LAST_LINE);
  assign w_last_row  = (w_row == LAST_ROW);
  assign w_out_val   = (BLOCK_ROWS == 1) ? w_d : min8(w_mem_rd, w_d);

  // Position counters and registered block result
  always_ff @(negedge clkn or negedge resetn) begin
    if (!resetn) begin
      r_col             <= '0;
      r_line            <= '0;
      r_row             <= '0;
      io_bus.valid_dark <= 1'b0;
      io_bus.dark_val   <= '0;
      io_bus.dark_col   <= '0;
      io_bus.dark_row   <= '0;
      io_bus.frame_done <= 1'b0;
    end else begin
      io_bus.valid_dark <= 1'b0;
      io_bus.dark_val   <= '0;
      io_bus.dark_col   <= '0;
      io_bus.dark_row   <= '0;
      io_bus.frame_done <= 1'b0;
      if (w_beat) begin
        if (w_last_line) begin
          io_bus.valid_dark <= 1'b1;
          io_bus.dark_val   <= w_out_val;
          io_bus.dark_col   <= w_col;
          io_bus.dark_row   <= w_row;
          io_bus.frame_done <= w_last_col && w_last_row;
        end
        r_col  <= w_last_col ? '0 : w_col + COL_W'(1);
        r_line <= w_last_col ? (w_last_line ? '0 : w_line + LINE_W'(1)) : w_line;
        r_row  <= (w_last_col && w_last_line) ? (w_last_row ? '0 : w_row + ROW_W'(1))
                                              : w_row;
      end else if (io_bus.frame_start) begin
        r_col  <= '0;
        r_line <= '0;
        r_row  <= '0;
      end
    end
  end

  // Line buffer: first line of a block overwrites, later lines keep the running min
  always_ff @(negedge clkn) begin
    if (w_beat && !w_last_line) begin
      r_mem[w_col] <= (w_line == '0) ? w_d : min8(w_mem_rd, w_d);
    end
  end

endmodule

// File: tb/tb_dark_block_min.sv
// Bench for dark_block_min: small-parameter instance with a scoreboard and
// vector table, plus one block row through a default-parameter instance.
module tb_dark_block_min;

  localparam int C = 4;
  localparam int R = 3;
  localparam int B = 2;

  typedef struct packed {
    logic       valid;
    logic [7:0] val;
    logic [1:0] col;
    logic [0:0] row;
    logic       fd;
  } exp_t;

  typedef struct {
    logic        fs;
    logic        v;
    logic [23:0] rgb;
    exp_t        e;
  } vec_t;

  logic  clkn;
  logic  resetn;
  int    n_tot, n_pass;
  int    n_valid, n_fd, n2;
  string phase;

  exp_t        sb[$];
  logic [22:0] q2[$];
  exp_t        mon_e;
  logic [22:0] mon2_e;

  int         m_col, m_line, m_row;
  logic [7:0] m_mem [C];

  dark_block_min_if #(.COL_W(2), .ROW_W(1)) bus ();
  dark_block_min_if #(.COL_W(7), .ROW_W(6)) bus2 ();

  dark_block_min #(
    .CELLS_PER_LINE(C), .BLOCK_ROWS(R), .BLOCKS_PER_FRM(B), .COL_W(2), .ROW_W(1)
  ) dut (
    .clkn(clkn), .resetn(resetn), .io_bus(bus)
  );

  dark_block_min dut_def (
    .clkn(clkn), .resetn(resetn), .io_bus(bus2)
  );

  initial clkn = 1'b0;
  always #5 clkn = ~clkn;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s [%s] got=%h exp=%h", name, phase, got, exp);
  endtask

  function automatic logic [7:0] min3(input logic [23:0] x);
    logic [7:0] m;
    m = x[23:16];
    if (x[15:8] < m) m = x[15:8];
    if (x[7:0] < m) m = x[7:0];
    return m;
  endfunction

  // Reference behaviour of the small instance, one cycle at a time
  task automatic model_step(input logic rst, input logic fs, input logic v,
                            input logic [23:0] rgb, output exp_t e);
    int c, l, r;
    logic [7:0] d;
    e = '0;
    d = min3(rgb);
    if (!rst) begin
      m_col = 0; m_line = 0; m_row = 0;
    end else if (v) begin
      c = fs ? 0 : m_col;
      l = fs ? 0 : m_line;
      r = fs ? 0 : m_row;
      if (l == R - 1) begin
        e.valid = 1'b1;
        e.val   = (m_mem[c] < d) ? m_mem[c] : d;
        e.col   = 2'(c);
        e.row   = 1'(r);
        e.fd    = (c == C - 1) && (r == B - 1);
      end else if (l == 0) begin
        m_mem[c] = d;
      end else if (d < m_mem[c]) begin
        m_mem[c] = d;
      end
      if (c == C - 1) begin
        c = 0;
        if (l == R - 1) begin
          l = 0;
          r = (r == B - 1) ? 0 : r + 1;
        end else l = l + 1;
      end else c = c + 1;
      m_col = c; m_line = l; m_row = r;
    end else if (fs) begin
      m_col = 0; m_line = 0; m_row = 0;
    end
  endtask

  task automatic drive(input logic rst, input logic fs, input logic v,
                       input logic [23:0] rgb, output exp_t me);
    @(posedge clkn);
    resetn = rst;
    bus.frame_start = fs;
    bus.valid_min_RGB = v;
    bus.min_RGB = rgb;
    model_step(rst, fs, v, rgb, me);
  endtask

  task automatic cyc(input logic rst, input logic fs, input logic v, input logic [23:0] rgb);
    exp_t me;
    drive(rst, fs, v, rgb, me);
    sb.push_back(me);
  endtask

  // Table rows carry their own expectation; the model only tracks state
  task automatic tcyc(input vec_t t);
    exp_t me;
    drive(1'b1, t.fs, t.v, t.rgb, me);
    sb.push_back(t.e);
  endtask

  function automatic vec_t mk(input logic v, input logic [23:0] rgb, input logic ev,
                              input logic [7:0] val, input logic [1:0] col);
    vec_t t;
    t.fs = 1'b0;
    t.v = v;
    t.rgb = rgb;
    t.e = '{valid: ev, val: ev ? val : 8'h00, col: ev ? col : 2'd0, row: 1'b0, fd: 1'b0};
    return t;
  endfunction

  // Small instance: every driven cycle is checked at the following negedge
  always @(negedge clkn) begin
    #2;
    if (bus.valid_dark) n_valid++;
    if (bus.frame_done) n_fd++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("out", 32'({bus.valid_dark, bus.dark_val, bus.dark_col, bus.dark_row,
                        bus.frame_done}), 32'(mon_e));
    end
  end

  // Default instance: each result must match the next queued block minimum
  always @(negedge clkn) begin
    #2;
    if (bus2.valid_dark) begin
      n2++;
      check("def_expected", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        mon2_e = q2.pop_front();
        check("def_out", 32'({bus2.valid_dark, bus2.dark_val, bus2.dark_col,
                              bus2.dark_row, bus2.frame_done}), 32'(mon2_e));
      end
    end
  end

  function automatic logic [7:0] dpat(input int c, input int l);
    return 8'((c * 37 + l * 101 + (c ^ l) * 11 + 29) % 256);
  endfunction

  initial begin
    vec_t tab [14];
    logic [7:0] mn, d;
    n_tot = 0; n_pass = 0; n_valid = 0; n_fd = 0; n2 = 0;
    m_col = 0; m_line = 0; m_row = 0;
    for (int i = 0; i < C; i++) m_mem[i] = 8'h00;
    resetn = 1'b0;
    bus.frame_start = 1'b0; bus.valid_min_RGB = 1'b0; bus.min_RGB = '0;
    bus2.frame_start = 1'b0; bus2.valid_min_RGB = 1'b0; bus2.min_RGB = '0;

    // Reset held with beats driven: outputs stay 0
    phase = "T1";
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 24'h010203);

    // Vertical min table, first beat after release is col 0 line 0
    phase = "T3";
    tab[0]  = mk(1, {8'd10, 8'hF0, 8'hFE}, 0, 0, 0);
    tab[1]  = mk(1, {8'hF0, 8'd50, 8'hFE}, 0, 0, 0);
    tab[2]  = mk(1, {8'hF0, 8'hFE, 8'd90}, 0, 0, 0);
    tab[3]  = mk(1, {8'hF0, 8'd60, 8'hFE}, 0, 0, 0);
    tab[4]  = mk(0, 24'h000000, 0, 0, 0);
    tab[5]  = mk(1, {8'd20, 8'hF0, 8'hFE}, 0, 0, 0);
    tab[6]  = mk(1, {8'hF0, 8'd40, 8'hFE}, 0, 0, 0);
    tab[7]  = mk(1, {8'hF0, 8'hFE, 8'd30}, 0, 0, 0);
    tab[8]  = mk(1, {8'hF0, 8'd60, 8'hFE}, 0, 0, 0);
    tab[9]  = mk(0, 24'h000000, 0, 0, 0);
    tab[10] = mk(1, {8'd15, 8'hF0, 8'hFE}, 1, 8'd10, 2'd0);
    tab[11] = mk(1, {8'hF0, 8'd45, 8'hFE}, 1, 8'd40, 2'd1);
    tab[12] = mk(1, {8'hF0, 8'hFE, 8'd70}, 1, 8'd30, 2'd2);
    tab[13] = mk(1, {8'hF0, 8'd5,  8'hFE}, 1, 8'd5,  2'd3);
    for (int i = 0; i < 14; i++) tcyc(tab[i]);

    // Channel min; frame_start arrives together with the first beat
    phase = "T2";
    for (int i = 0; i < 12; i++) cyc(1'b1, i == 0, 1'b1, 24'h402080);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, 24'h05FF10);

    // Full frame back-to-back, then the wrapped frame with idle gaps
    phase = "T4";
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    n_valid = 0; n_fd = 0;
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    check("frame_outputs", 32'(n_valid), 32'd8);
    check("frame_done_count", 32'(n_fd), 32'd1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
      repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, 1'b0, 24'h0);
    end

    // Aborted partial block of zeros must not leak into the next block
    phase = "T5";
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 24'h000000);
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    n_valid = 0;
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, {8'd220, 8'd200, 8'd250});
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    check("block_outputs", 32'(n_valid), 32'd4);

    // Async reset right after an output clears it without waiting for a clock
    phase = "T6";
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    @(posedge clkn);
    check("pre_reset_valid", 32'(bus.valid_dark), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_clear", 32'({bus.valid_dark, bus.dark_val, bus.dark_col, bus.dark_row,
                              bus.frame_done}), 32'd0);
    m_col = 0; m_line = 0; m_row = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 24'($urandom));
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, 24'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 24'h0);

    // Default parameters: one block row of 80x24 cells
    phase = "DEF";
    for (int c = 0; c < 80; c++) begin
      mn = 8'hFF;
      for (int l = 0; l < 24; l++) begin
        d = dpat(c, l);
        if (d < mn) mn = d;
      end
      q2.push_back({1'b1, mn, 7'(c), 6'd0, 1'b0});
    end
    @(posedge clkn);
    bus2.frame_start = 1'b1;
    @(posedge clkn);
    bus2.frame_start = 1'b0;
    for (int l = 0; l < 24; l++) begin
      for (int c = 0; c < 80; c++) begin
        d = dpat(c, l);
        @(posedge clkn);
        bus2.valid_min_RGB = 1'b1;
        case ((c + l) % 3)
          0:       bus2.min_RGB = {d, 8'hFF, 8'hFF};
          1:       bus2.min_RGB = {8'hFF, d, 8'hFF};
          default: bus2.min_RGB = {8'hFF, 8'hFF, d};
        endcase
        if ((c + l) % 17 == 0) begin
          @(posedge clkn);
          bus2.valid_min_RGB = 1'b0;
        end
      end
    end
    @(posedge clkn);
    bus2.valid_min_RGB = 1'b0;
    repeat (4) @(posedge clkn);
    check("def_count", 32'(n2), 32'd80);
    check("def_queue_empty", 32'(q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
